// File: rtl/ex_stage_if.sv
// Signal bundle between the pipeline control/ID side and the execute stage.
// master = pipeline side (drives stall and the ID->EX bus), slave = ex_stage.
interface ex_stage_if #(
   parameter int ID_TO_EX_WD  = 239,
   parameter int EX_TO_MEM_WD = 150,
   parameter int EX_TO_RF_WD  = 104,
   parameter int STALL_WD     = 6
);
   logic [STALL_WD-1:0]     stall;
   logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
   logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
   logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus;
   logic                    data_sram_en;
   logic [3:0]              data_sram_wen;
   logic [31:0]             data_sram_addr;
   logic [31:0]             data_sram_wdata;
   logic                    stallreq_for_ex;

   modport master (
      output stall, id_to_ex_bus,
      input  ex_to_mem_bus, ex_to_rf_bus, data_sram_en, data_sram_wen,
      input  data_sram_addr, data_sram_wdata, stallreq_for_ex
   );

   modport slave (
      input  stall, id_to_ex_bus,
      output ex_to_mem_bus, ex_to_rf_bus, data_sram_en, data_sram_wen,
      output data_sram_addr, data_sram_wdata, stallreq_for_ex
   );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: ID->EX register, ALU, address generation, HI/LO ops
// including single-cycle multiply and a 32-step restoring divider that stalls.
module ex_stage #(
   parameter int ID_TO_EX_WD  = 239,
   parameter int EX_TO_MEM_WD = 150,
   parameter int EX_TO_RF_WD  = 104,
   parameter int STALL_WD     = 6
) (
   input  logic       clk,
   input  logic       rst,
   ex_stage_if.slave  ex_if
);
   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_END} div_state_e;

   logic [ID_TO_EX_WD-1:0] id_to_ex_q, id_to_ex_d;
   logic [STALL_WD-1:0]    stall;

   logic [31:0] lo_in, hi_in, ex_pc, inst, rdata1, rdata2;
   logic [7:0]  hilo_op, mem_op;
   logic [11:0] alu_op;
   logic [2:0]  sel_src1;
   logic [3:0]  sel_src2, ram_wen;
   logic        ram_en, rf_we, sel_rf_res;
   logic [4:0]  rf_waddr;

   assign stall = ex_if.stall;

   // Stop on ID with EX running inserts a bubble; otherwise ID stop holds EX.
   always_comb begin
      id_to_ex_d = id_to_ex_q;
      if (stall[2] && !stall[3]) begin
         id_to_ex_d = '0;
      end else if (!stall[2]) begin
         id_to_ex_d = ex_if.id_to_ex_bus;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         id_to_ex_q <= '0;
      end else begin
         id_to_ex_q <= id_to_ex_d;
      end
   end

   assign lo_in      = id_to_ex_q[238:207];
   assign hi_in      = id_to_ex_q[206:175];
   assign hilo_op    = id_to_ex_q[174:167];
   assign mem_op     = id_to_ex_q[166:159];
   assign ex_pc      = id_to_ex_q[158:127];
   assign inst       = id_to_ex_q[126:95];
   assign alu_op     = id_to_ex_q[94:83];
   assign sel_src1   = id_to_ex_q[82:80];
   assign sel_src2   = id_to_ex_q[79:76];
   assign ram_en     = id_to_ex_q[75];
   assign ram_wen    = id_to_ex_q[74:71];
   assign rf_we      = id_to_ex_q[70];
   assign rf_waddr   = id_to_ex_q[69:65];
   assign sel_rf_res = id_to_ex_q[64];
   assign rdata1     = id_to_ex_q[63:32];
   assign rdata2     = id_to_ex_q[31:0];

   logic [31:0] src1, src2, imm_sext, imm_zext;
   assign imm_sext = {{16{inst[15]}}, inst[15:0]};
   assign imm_zext = {16'b0, inst[15:0]};

   assign src1 = ({32{sel_src1[0]}} & rdata1)
               | ({32{sel_src1[1]}} & ex_pc)
               | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
   assign src2 = ({32{sel_src2[0]}} & rdata2)
               | ({32{sel_src2[1]}} & imm_sext)
               | ({32{sel_src2[2]}} & 32'd8)
               | ({32{sel_src2[3]}} & imm_zext);

   // One candidate per alu_op bit; the one-hot op selects via AND-OR.
   logic [31:0] alu_cand [12];
   logic [31:0] alu_mask [12];
   logic [31:0] alu_result;

   assign alu_cand[11] = src1 + src2;
   assign alu_cand[10] = src1 - src2;
   assign alu_cand[9]  = {31'b0, $signed(src1) < $signed(src2)};
   assign alu_cand[8]  = {31'b0, src1 < src2};
   assign alu_cand[7]  = src1 & src2;
   assign alu_cand[6]  = ~(src1 | src2);
   assign alu_cand[5]  = src1 | src2;
   assign alu_cand[4]  = src1 ^ src2;
   assign alu_cand[3]  = src2 << src1[4:0];
   assign alu_cand[2]  = src2 >> src1[4:0];
   assign alu_cand[1]  = $signed(src2) >>> src1[4:0];
   assign alu_cand[0]  = {src2[15:0], 16'b0};

   generate
      for (genvar gi = 0; gi < 12; gi++) begin : g_alu
         assign alu_mask[gi] = alu_cand[gi] & {32{alu_op[gi]}};
      end
   endgenerate

   always_comb begin
      alu_result = '0;
      for (int i = 0; i < 12; i++) begin
         alu_result = alu_result | alu_mask[i];
      end
   end

   logic op_mflo, op_mfhi, op_mthi, op_mtlo, op_mult, op_multu, op_div, op_divu, is_div_op;
   assign op_mflo  = hilo_op[7];
   assign op_mfhi  = hilo_op[6];
   assign op_mthi  = hilo_op[5];
   assign op_mtlo  = hilo_op[4];
   assign op_mult  = hilo_op[3];
   assign op_multu = hilo_op[2];
   assign op_div   = hilo_op[1];
   assign op_divu  = hilo_op[0];
   assign is_div_op = op_div | op_divu;

   logic [31:0] ex_result;
   assign ex_result = op_mfhi ? hi_in : (op_mflo ? lo_in : alu_result);

   logic [63:0] mul_s, mul_u;
   assign mul_s = $signed({{32{rdata1[31]}}, rdata1}) * $signed({{32{rdata2[31]}}, rdata2});
   assign mul_u = {32'b0, rdata1} * {32'b0, rdata2};

   // Divider datapath: rem/quo shift left together, quo starts as the dividend.
   div_state_e  div_state_q;
   logic [4:0]  div_cnt_q;
   logic [31:0] div_rem_q, div_quo_q, div_den_q;
   logic        div_qneg_q, div_rneg_q;

   logic [31:0] dividend_abs, divisor_abs, step_rem, step_quo;
   logic [32:0] step_trial, step_diff;
   logic        step_ge;

   assign dividend_abs = (op_div && rdata1[31]) ? (32'd0 - rdata1) : rdata1;
   assign divisor_abs  = (op_div && rdata2[31]) ? (32'd0 - rdata2) : rdata2;
   assign step_trial   = {div_rem_q, div_quo_q[31]};
   assign step_diff    = step_trial - {1'b0, div_den_q};
   assign step_ge      = ~step_diff[32];
   assign step_rem     = step_ge ? step_diff[31:0] : step_trial[31:0];
   assign step_quo     = {div_quo_q[30:0], step_ge};

   always_ff @(posedge clk) begin
      if (rst) begin
         div_state_q <= DIV_IDLE;
         div_cnt_q   <= '0;
         div_rem_q   <= '0;
         div_quo_q   <= '0;
         div_den_q   <= '0;
         div_qneg_q  <= 1'b0;
         div_rneg_q  <= 1'b0;
      end else begin
         case (div_state_q)
            DIV_IDLE: begin
               if (is_div_op) begin
                  div_cnt_q <= '0;
                  if (rdata2 == 32'd0) begin
                     // Divide by zero: result is ready immediately, no sign fix.
                     div_quo_q   <= 32'hFFFF_FFFF;
                     div_rem_q   <= rdata1;
                     div_den_q   <= '0;
                     div_qneg_q  <= 1'b0;
                     div_rneg_q  <= 1'b0;
                     div_state_q <= DIV_END;
                  end else begin
                     div_quo_q   <= dividend_abs;
                     div_rem_q   <= '0;
                     div_den_q   <= divisor_abs;
                     div_qneg_q  <= op_div & (rdata1[31] ^ rdata2[31]);
                     div_rneg_q  <= op_div & rdata1[31];
                     div_state_q <= DIV_BUSY;
                  end
               end
            end
            DIV_BUSY: begin
               div_rem_q <= step_rem;
               div_quo_q <= step_quo;
               div_cnt_q <= div_cnt_q + 5'd1;
               if (div_cnt_q == 5'd31) begin
                  div_state_q <= DIV_END;
               end
            end
            DIV_END: begin
               div_state_q <= DIV_IDLE;
            end
            default: begin
               div_state_q <= DIV_IDLE;
            end
         endcase
      end
   end

   logic [31:0] hi_val, lo_val;
   logic        hi_we, lo_we;

   always_comb begin
      hi_val = hi_in;
      lo_val = lo_in;
      hi_we  = 1'b0;
      lo_we  = 1'b0;
      if (div_state_q == DIV_END) begin
         hi_val = div_rneg_q ? (32'd0 - div_rem_q) : div_rem_q;
         lo_val = div_qneg_q ? (32'd0 - div_quo_q) : div_quo_q;
         hi_we  = 1'b1;
         lo_we  = 1'b1;
      end else if (!is_div_op) begin
         if (op_mult) begin
            hi_val = mul_s[63:32];
            lo_val = mul_s[31:0];
            hi_we  = 1'b1;
            lo_we  = 1'b1;
         end else if (op_multu) begin
            hi_val = mul_u[63:32];
            lo_val = mul_u[31:0];
            hi_we  = 1'b1;
            lo_we  = 1'b1;
         end
         if (op_mthi) begin
            hi_val = rdata1;
            hi_we  = 1'b1;
         end
         if (op_mtlo) begin
            lo_val = rdata1;
            lo_we  = 1'b1;
         end
      end
   end

   logic [EX_TO_MEM_WD-1:0] mem_bus;
   logic [EX_TO_RF_WD-1:0]  rf_bus;

   assign mem_bus = {mem_op, lo_val, lo_we, hi_val, hi_we, ex_pc, ram_en, ram_wen,
                     sel_rf_res, rf_we, rf_waddr, ex_result};
   // Loads cannot forward from EX: their data only exists after MEM.
   assign rf_bus  = {lo_val, lo_we, hi_val, hi_we, rf_we & ~sel_rf_res, rf_waddr, ex_result};

   assign ex_if.ex_to_mem_bus   = mem_bus;
   assign ex_if.ex_to_rf_bus    = rf_bus;
   assign ex_if.data_sram_en    = ram_en;
   assign ex_if.data_sram_wen   = ram_wen;
   assign ex_if.data_sram_addr  = ex_result;
   assign ex_if.data_sram_wdata = rdata2;
   assign ex_if.stallreq_for_ex = ((div_state_q == DIV_IDLE) && is_div_op) || (div_state_q == DIV_BUSY);

   logic unused_ok;
   assign unused_ok = ^{stall[STALL_WD-1:4], stall[1:0], inst[31:16]};
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU, memory address, MULT/MTHI/MFHI, divider and stalls.
module tb_ex_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [5:0] man_stall = 6'b0;
   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ex_stage_if ifc ();

   ex_stage dut (
      .clk   (clk),
      .rst   (rst),
      .ex_if (ifc.slave)
   );

   // Stall controller: a pending EX stall request freezes IF/ID/EX.
   assign ifc.stall = ifc.stallreq_for_ex ? 6'b001111 : man_stall;

   wire [31:0] res     = ifc.ex_to_mem_bus[31:0];
   wire [31:0] mem_lo  = ifc.ex_to_mem_bus[141:110];
   wire        mem_lwe = ifc.ex_to_mem_bus[109];
   wire [31:0] mem_hi  = ifc.ex_to_mem_bus[108:77];
   wire        mem_hwe = ifc.ex_to_mem_bus[76];
   wire        mem_rfwe = ifc.ex_to_mem_bus[37];
   wire [31:0] rf_lo   = ifc.ex_to_rf_bus[103:72];
   wire        rf_lwe  = ifc.ex_to_rf_bus[71];
   wire [31:0] rf_hi   = ifc.ex_to_rf_bus[70:39];
   wire        rf_hwe  = ifc.ex_to_rf_bus[38];
   wire        rf_rfwe = ifc.ex_to_rf_bus[37];
   wire [31:0] rf_wd   = ifc.ex_to_rf_bus[31:0];

   function automatic logic [238:0] mk(
      input logic [7:0] hilo, input logic [31:0] pc, input logic [31:0] inst,
      input logic [11:0] alu, input logic [2:0] s1, input logic [3:0] s2,
      input logic ren, input logic [3:0] rwen, input logic rfwe, input logic [4:0] wa,
      input logic selres, input logic [31:0] r1, input logic [31:0] r2,
      input logic [31:0] hi, input logic [31:0] lo);
      return {lo, hi, hilo, 8'h00, pc, inst, alu, s1, s2, ren, rwen, rfwe, wa, selres, r1, r2};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [238:0] b);
      ifc.id_to_ex_bus = b;
      step();
   endtask

   task automatic test_reset();
      ifc.id_to_ex_bus = mk(8'h02, 32'h1234, 32'hFFFF, 12'h800, 3'b001, 4'b0001, 1'b1, 4'hF,
                            1'b1, 5'd3, 1'b0, 32'h77, 32'h5, 32'h1, 32'h2);
      rst = 1'b1;
      step();
      step();
      n_cmp++; if (ifc.ex_to_mem_bus !== 150'b0) begin n_fail++; $display("FAIL reset_mem_bus: got %h want 0", ifc.ex_to_mem_bus); end
      n_cmp++; if (ifc.ex_to_rf_bus !== 104'b0) begin n_fail++; $display("FAIL reset_rf_bus: got %h want 0", ifc.ex_to_rf_bus); end
      n_cmp++; if ({ifc.data_sram_en, ifc.data_sram_wen, ifc.data_sram_addr, ifc.data_sram_wdata} !== 69'b0) begin
         n_fail++; $display("FAIL reset_sram: got en=%b wen=%h addr=%h wdata=%h want 0", ifc.data_sram_en, ifc.data_sram_wen, ifc.data_sram_addr, ifc.data_sram_wdata); end
      n_cmp++; if (ifc.stallreq_for_ex !== 1'b0) begin n_fail++; $display("FAIL reset_stallreq: got %b want 0", ifc.stallreq_for_ex); end
      ifc.id_to_ex_bus = '0;
      rst = 1'b0;
      step();
      $display("tx reset: outputs cleared, stallreq=%b", ifc.stallreq_for_ex);
   endtask

   task automatic test_alu();
      load(mk(8'h00, 32'h0, 32'h0, 12'h800, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0));
      $display("tx addu: result=%h", res);
      n_cmp++; if (res !== 32'h0) begin n_fail++; $display("FAIL addu_wrap: got %h want 00000000", res); end
      n_cmp++; if ({rf_rfwe, rf_wd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL addu_fwd: got we=%b wd=%h want we=1 wd=0", rf_rfwe, rf_wd); end
      load(mk(8'h00, 32'h0, 32'h0, 12'h200, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0));
      $display("tx slt: result=%h", res);
      n_cmp++; if (res !== 32'h1) begin n_fail++; $display("FAIL slt: got %h want 00000001", res); end
      load(mk(8'h00, 32'h0, 32'h0, 12'h100, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0));
      $display("tx sltu: result=%h", res);
      n_cmp++; if (res !== 32'h0) begin n_fail++; $display("FAIL sltu: got %h want 00000000", res); end
      load(mk(8'h00, 32'h0, 32'h0, 12'h002, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h4, 32'h80000000, 32'h0, 32'h0));
      $display("tx sra: result=%h", res);
      n_cmp++; if (res !== 32'hF8000000) begin n_fail++; $display("FAIL sra: got %h want f8000000", res); end
      load(mk(8'h00, 32'h0, 32'h3C011234, 12'h001, 3'b000, 4'b1000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0));
      $display("tx lui: result=%h", res);
      n_cmp++; if (res !== 32'h12340000) begin n_fail++; $display("FAIL lui: got %h want 12340000", res); end
      // sll by the sa field (inst[10:6] = 4)
      load(mk(8'h00, 32'h0, 32'h00000100, 12'h008, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h1, 32'h0, 32'h0));
      $display("tx sll_sa: result=%h", res);
      n_cmp++; if (res !== 32'h10) begin n_fail++; $display("FAIL sll_sa: got %h want 00000010", res); end
      load(mk(8'h00, 32'hBFC00010, 32'h0, 12'h800, 3'b010, 4'b0100, 1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0));
      $display("tx jal_link: result=%h", res);
      n_cmp++; if (res !== 32'hBFC00018) begin n_fail++; $display("FAIL link_addr: got %h want bfc00018", res); end
   endtask

   task automatic test_mem();
      load(mk(8'h00, 32'h0, 32'hAC00FFFC, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h1000, 32'hDEADBEEF, 32'h0, 32'h0));
      $display("tx sw: addr=%h wen=%h wdata=%h", ifc.data_sram_addr, ifc.data_sram_wen, ifc.data_sram_wdata);
      n_cmp++; if (ifc.data_sram_addr !== 32'h0FFC) begin n_fail++; $display("FAIL sw_addr: got %h want 00000ffc", ifc.data_sram_addr); end
      n_cmp++; if ({ifc.data_sram_en, ifc.data_sram_wen} !== 5'b1_1111) begin n_fail++; $display("FAIL sw_en_wen: got en=%b wen=%h want en=1 wen=f", ifc.data_sram_en, ifc.data_sram_wen); end
      n_cmp++; if (ifc.data_sram_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata: got %h want deadbeef", ifc.data_sram_wdata); end
      // load: writes the RF through MEM but must not forward from EX
      load(mk(8'h00, 32'h0, 32'h8C000004, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd9, 1'b1, 32'h2000, 32'h0, 32'h0, 32'h0));
      $display("tx lw: addr=%h mem_rfwe=%b fwd_rfwe=%b", ifc.data_sram_addr, mem_rfwe, rf_rfwe);
      n_cmp++; if ({mem_rfwe, rf_rfwe} !== 2'b10) begin n_fail++; $display("FAIL lw_fwd_we: got mem=%b fwd=%b want mem=1 fwd=0", mem_rfwe, rf_rfwe); end
      n_cmp++; if (ifc.data_sram_addr !== 32'h2004) begin n_fail++; $display("FAIL lw_addr: got %h want 00002004", ifc.data_sram_addr); end
   endtask

   task automatic test_hilo();
      load(mk(8'h08, 32'h0, 32'h0, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'hFFFFFFFD, 32'h7, 32'h0, 32'h0));
      $display("tx mult: hi=%h lo=%h we=%b%b", rf_hi, rf_lo, rf_hwe, rf_lwe);
      n_cmp++; if ({rf_hi, rf_lo} !== {32'hFFFFFFFF, 32'hFFFFFFEB}) begin n_fail++; $display("FAIL mult_rf: got hi=%h lo=%h want ffffffff ffffffeb", rf_hi, rf_lo); end
      n_cmp++; if ({rf_hwe, rf_lwe, mem_hwe, mem_lwe} !== 4'hF) begin n_fail++; $display("FAIL mult_we: got %b%b%b%b want 1111", rf_hwe, rf_lwe, mem_hwe, mem_lwe); end
      n_cmp++; if ({mem_hi, mem_lo} !== {32'hFFFFFFFF, 32'hFFFFFFEB}) begin n_fail++; $display("FAIL mult_mem: got hi=%h lo=%h want ffffffff ffffffeb", mem_hi, mem_lo); end
      load(mk(8'h04, 32'h0, 32'h0, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0));
      $display("tx multu: hi=%h lo=%h", rf_hi, rf_lo);
      n_cmp++; if ({rf_hi, rf_lo} !== {32'h1, 32'hFFFFFFFE}) begin n_fail++; $display("FAIL multu: got hi=%h lo=%h want 00000001 fffffffe", rf_hi, rf_lo); end
      load(mk(8'h20, 32'h0, 32'h0, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'hCAFEF00D, 32'h0, 32'h11, 32'h22));
      $display("tx mthi: hi=%h lo=%h we=%b%b", rf_hi, rf_lo, rf_hwe, rf_lwe);
      n_cmp++; if ({rf_hi, rf_hwe, rf_lwe} !== {32'hCAFEF00D, 2'b10}) begin n_fail++; $display("FAIL mthi: got hi=%h we=%b%b want cafef00d 10", rf_hi, rf_hwe, rf_lwe); end
      load(mk(8'h40, 32'h0, 32'h0, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'h0, 32'h0, 32'h12345678, 32'h9ABCDEF0));
      $display("tx mfhi: result=%h", res);
      n_cmp++; if ({res, rf_hwe, rf_lwe} !== {32'h12345678, 2'b00}) begin n_fail++; $display("FAIL mfhi: got %h we=%b%b want 12345678 00", res, rf_hwe, rf_lwe); end
   endtask

   task automatic test_div();
      int cnt;
      // DIV -7 / 2
      load(mk(8'h02, 32'h0, 32'h0, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'hFFFFFFF9, 32'h2, 32'h0, 32'h0));
      ifc.id_to_ex_bus = '0;
      n_cmp++; if ({rf_hwe, rf_lwe} !== 2'b00) begin n_fail++; $display("FAIL div_busy_we: got %b%b want 00", rf_hwe, rf_lwe); end
      cnt = 0;
      while (ifc.stallreq_for_ex === 1'b1 && cnt < 100) begin cnt++; step(); end
      $display("tx div: stall_cycles=%0d hi=%h lo=%h", cnt, rf_hi, rf_lo);
      n_cmp++; if (cnt !== 33) begin n_fail++; $display("FAIL div_stall_len: got %0d want 33", cnt); end
      n_cmp++; if ({rf_hi, rf_lo, rf_hwe, rf_lwe} !== {32'hFFFFFFFF, 32'hFFFFFFFD, 2'b11}) begin
         n_fail++; $display("FAIL div_result: got hi=%h lo=%h we=%b%b want ffffffff fffffffd 11", rf_hi, rf_lo, rf_hwe, rf_lwe); end
      step();
      n_cmp++; if ({rf_hwe, rf_lwe, ifc.stallreq_for_ex} !== 3'b000) begin n_fail++; $display("FAIL div_end_one_cycle: got we=%b%b stall=%b want 000", rf_hwe, rf_lwe, ifc.stallreq_for_ex); end
      // DIVU 0xFFFFFFFF / 16
      load(mk(8'h01, 32'h0, 32'h0, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'hFFFFFFFF, 32'h10, 32'h0, 32'h0));
      ifc.id_to_ex_bus = '0;
      cnt = 0;
      while (ifc.stallreq_for_ex === 1'b1 && cnt < 100) begin cnt++; step(); end
      $display("tx divu: stall_cycles=%0d hi=%h lo=%h", cnt, mem_hi, mem_lo);
      n_cmp++; if ({mem_hi, mem_lo, mem_hwe, mem_lwe} !== {32'hF, 32'h0FFFFFFF, 2'b11}) begin
         n_fail++; $display("FAIL divu_result: got hi=%h lo=%h we=%b%b want 0000000f 0fffffff 11", mem_hi, mem_lo, mem_hwe, mem_lwe); end
      step();
      // DIV 5 / 0
      load(mk(8'h02, 32'h0, 32'h0, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h5, 32'h0, 32'h0, 32'h0));
      ifc.id_to_ex_bus = '0;
      cnt = 0;
      while (ifc.stallreq_for_ex === 1'b1 && cnt < 100) begin cnt++; step(); end
      $display("tx div0: stall_cycles=%0d hi=%h lo=%h", cnt, rf_hi, rf_lo);
      n_cmp++; if (cnt !== 1) begin n_fail++; $display("FAIL div0_stall_len: got %0d want 1", cnt); end
      n_cmp++; if ({rf_hi, rf_lo, rf_hwe, rf_lwe} !== {32'h5, 32'hFFFFFFFF, 2'b11}) begin
         n_fail++; $display("FAIL div0_result: got hi=%h lo=%h we=%b%b want 00000005 ffffffff 11", rf_hi, rf_lo, rf_hwe, rf_lwe); end
      step();
   endtask

   task automatic test_reset_busy();
      load(mk(8'h02, 32'h0, 32'h0, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd100, 32'd3, 32'h0, 32'h0));
      ifc.id_to_ex_bus = '0;
      for (int i = 0; i < 5; i++) step();
      n_cmp++; if (ifc.stallreq_for_ex !== 1'b1) begin n_fail++; $display("FAIL busy_stallreq: got %b want 1", ifc.stallreq_for_ex); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      $display("tx reset_busy: stallreq=%b", ifc.stallreq_for_ex);
      n_cmp++; if ({ifc.stallreq_for_ex, rf_hwe, rf_lwe} !== 3'b000) begin n_fail++; $display("FAIL reset_busy: got stall=%b we=%b%b want 000", ifc.stallreq_for_ex, rf_hwe, rf_lwe); end
      step();
      n_cmp++; if (ifc.stallreq_for_ex !== 1'b0) begin n_fail++; $display("FAIL reset_busy_idle: got %b want 0", ifc.stallreq_for_ex); end
   endtask

   task automatic test_stall_bubble();
      load(mk(8'h00, 32'h0, 32'h0, 12'h800, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd40, 32'd2, 32'h0, 32'h0));
      // ID and EX both stopped: EX holds the add despite a new bus value
      man_stall = 6'b001100;
      load(mk(8'h00, 32'h0, 32'h0, 12'h400, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd9, 32'd1, 32'h0, 32'h0));
      $display("tx hold: result=%h", res);
      n_cmp++; if (res !== 32'd42) begin n_fail++; $display("FAIL hold: got %h want 0000002a", res); end
      // ID stopped, EX running: a bubble enters even though the bus holds a DIV
      man_stall = 6'b000100;
      load(mk(8'h02, 32'h0, 32'h0, 12'h800, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd1, 1'b0, 32'd7, 32'd1, 32'h0, 32'h0));
      $display("tx bubble: result=%h stallreq=%b", res, ifc.stallreq_for_ex);
      n_cmp++; if ({res, ifc.stallreq_for_ex, rf_rfwe} !== {32'h0, 2'b00}) begin n_fail++; $display("FAIL bubble: got %h stall=%b we=%b want 0 0 0", res, ifc.stallreq_for_ex, rf_rfwe); end
      man_stall = 6'b0;
      ifc.id_to_ex_bus = '0;
      step();
   endtask

   initial begin
      ifc.id_to_ex_bus = '0;
      test_reset();
      test_alu();
      test_mem();
      test_hilo();
      test_div();
      test_reset_busy();
      test_stall_bubble();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
